// File: rtl/datamem_arbiter.sv
// Round-robin arbiter and sequencer between the load/store unit (A) and the
// debug/loader port (B) in front of a single-port, range-checked data memory.
module datamem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_err,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;
  logic          win_b_q, win_b_d;
  logic          we_q, we_d;
  logic          range_ok_q, range_ok_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          sel_b;
  logic [AW-1:0] win_addr;
  logic          resp_a, resp_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      win_b_q    <= 1'b0;
      we_q       <= 1'b0;
      range_ok_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      win_b_q    <= win_b_d;
      we_q       <= we_d;
      range_ok_q <= range_ok_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    win_b_d    = win_b_q;
    we_d       = we_q;
    range_ok_d = range_ok_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    // On contention B wins only when A was served last.
    sel_b      = b_req && (!a_req || !last_b_q);
    win_addr   = sel_b ? b_addr : a_addr;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          win_b_d    = sel_b;
          we_d       = sel_b ? b_we : a_we;
          addr_d     = win_addr;
          wdata_d    = sel_b ? b_wdata : a_wdata;
          range_ok_d = (win_addr < AW'(DEPTH));
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Writes and out-of-range accesses never expose memory contents.
        rdata_d = (!we_q && range_ok_q) ? mem_rdata : '0;
        state_d = RESP;
      end
      RESP: begin
        last_b_d = win_b_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp_a    = (state_q == RESP) && !win_b_q;
  assign resp_b    = (state_q == RESP) &&  win_b_q;

  assign a_ack     = resp_a;
  assign a_rdata   = resp_a ? rdata_q : '0;
  assign a_err     = resp_a && !range_ok_q;
  assign b_ack     = resp_b;
  assign b_rdata   = resp_b ? rdata_q : '0;
  assign b_err     = resp_b && !range_ok_q;

  assign mem_we    = (state_q == ACCESS) && we_q && range_ok_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
